// File: rtl/init_seq_ctrl.sv
// Power-up sequencer: enables channels one at a time, waits for a debounced
// confirmation per channel, and latches a fault on stage timeout or sensor loss.
module init_seq_ctrl #(
    parameter int N_CH    = 4,
    parameter int DEB_CYC = 2,
    parameter int TMO_CYC = 15,
    localparam int IW     = (N_CH < 2) ? 1 : $clog2(N_CH)
) (
    input  logic            Ck,
    input  logic            Clr,
    input  logic            St,
    input  logic [N_CH-1:0] I,
    output logic [N_CH-1:0] O,
    output logic            H1,
    output logic            Busy,
    output logic            Flt,
    output logic [IW-1:0]   FltIdx,
    output logic [1:0]      fsm_state
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DONE  = 2'd2,
        FAULT = 2'd3
    } state_t;

    state_t         state;
    logic [IW-1:0]  s;
    logic [3:0]     deb;
    logic [15:0]    tmr;
    logic           st_q;

    logic           start;
    logic           cur_hi;
    logic           confirm;
    logic           timeout;
    logic           last;
    logic           loss_run;
    logic           loss_all;
    logic [IW-1:0]  loss_run_idx;
    logic [IW-1:0]  loss_all_idx;

    assign fsm_state = state;
    assign start     = St & ~st_q;
    assign cur_hi    = I[s];
    assign confirm   = cur_hi && (deb == 4'(DEB_CYC - 1));
    assign timeout   = (tmr == 16'(TMO_CYC - 1));
    assign last      = (s == IW'(N_CH - 1));

    // Descending scan so the lowest dropped channel wins.
    always_comb begin
        loss_run     = 1'b0;
        loss_all     = 1'b0;
        loss_run_idx = '0;
        loss_all_idx = '0;
        for (int j = N_CH - 1; j >= 0; j--) begin
            if (!I[j]) begin
                loss_all     = 1'b1;
                loss_all_idx = IW'(j);
                if (j < int'(s)) begin
                    loss_run     = 1'b1;
                    loss_run_idx = IW'(j);
                end
            end
        end
    end

    function automatic logic [N_CH-1:0] upto(input logic [IW-1:0] k);
        for (int b = 0; b < N_CH; b++) begin
            upto[b] = (b <= int'(k));
        end
    endfunction

    always_ff @(posedge Ck or negedge Clr) begin
        if (!Clr) begin
            state  <= IDLE;
            s      <= '0;
            deb    <= '0;
            tmr    <= '0;
            st_q   <= 1'b0;
            O      <= '0;
            H1     <= 1'b0;
            Busy   <= 1'b0;
            Flt    <= 1'b0;
            FltIdx <= '0;
        end else begin
            st_q <= St;
            case (state)
                IDLE, FAULT: begin
                    if (start) begin
                        state  <= RUN;
                        s      <= '0;
                        deb    <= '0;
                        tmr    <= '0;
                        O      <= N_CH'(1);
                        H1     <= 1'b0;
                        Busy   <= 1'b1;
                        Flt    <= 1'b0;
                        FltIdx <= '0;
                    end
                end
                RUN: begin
                    // Sensor loss outranks confirm, which outranks timeout.
                    if (loss_run) begin
                        state  <= FAULT;
                        O      <= '0;
                        Busy   <= 1'b0;
                        Flt    <= 1'b1;
                        FltIdx <= loss_run_idx;
                    end else if (confirm) begin
                        deb <= '0;
                        tmr <= '0;
                        if (last) begin
                            state <= DONE;
                            O     <= '1;
                            H1    <= 1'b1;
                            Busy  <= 1'b0;
                        end else begin
                            s <= s + IW'(1);
                            O <= upto(s + IW'(1));
                        end
                    end else if (timeout) begin
                        state  <= FAULT;
                        O      <= '0;
                        Busy   <= 1'b0;
                        Flt    <= 1'b1;
                        FltIdx <= s;
                    end else begin
                        deb <= cur_hi ? deb + 4'd1 : 4'd0;
                        tmr <= tmr + 16'd1;
                    end
                end
                DONE: begin
                    if (loss_all) begin
                        state  <= FAULT;
                        O      <= '0;
                        H1     <= 1'b0;
                        Busy   <= 1'b0;
                        Flt    <= 1'b1;
                        FltIdx <= loss_all_idx;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_init_seq_ctrl.sv
// Directed bench for init_seq_ctrl at N_CH=4, DEB_CYC=2, TMO_CYC=15.
// Observed outputs are packed as {O, H1, Busy, Flt, FltIdx}.
module tb_init_seq_ctrl;

    logic       Ck;
    logic       Clr;
    logic       St;
    logic [3:0] I;
    logic [3:0] O;
    logic       H1;
    logic       Busy;
    logic       Flt;
    logic [1:0] FltIdx;
    logic [1:0] fsm_state;

    int n_cmp;
    int n_err;
    logic [8:0] exp_q[$];

    init_seq_ctrl #(.N_CH(4), .DEB_CYC(2), .TMO_CYC(15)) dut (
        .Ck        (Ck),
        .Clr       (Clr),
        .St        (St),
        .I         (I),
        .O         (O),
        .H1        (H1),
        .Busy      (Busy),
        .Flt       (Flt),
        .FltIdx    (FltIdx),
        .fsm_state (fsm_state)
    );

    initial begin
        Ck = 1'b0;
        forever #5 Ck = ~Ck;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: run did not complete within time limit");
        $fatal(1, "watchdog");
    end

    function automatic logic [8:0] pk(input logic [3:0] o, input logic h1, input logic b,
                                      input logic f, input logic [1:0] ix);
        return {o, h1, b, f, ix};
    endfunction

    task automatic step();
        @(posedge Ck);
        #1;
    endtask

    task automatic check(input string tag, input logic [8:0] exp);
        logic [8:0] got;
        got = {O, H1, Busy, Flt, FltIdx};
        n_cmp++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed {O,H1,Busy,Flt,FltIdx}=%b expected %b", tag, got, exp);
        end
    endtask

    initial begin
        logic [8:0] idle_v;
        logic [8:0] exp_v;
        n_cmp  = 0;
        n_err  = 0;
        idle_v = pk(4'b0000, 1'b0, 1'b0, 1'b0, 2'd0);

        // Reset and idle
        Clr = 1'b0;
        St  = 1'b0;
        I   = 4'b0000;
        #12;
        check("reset_state", idle_v);
        Clr = 1'b1;
        step();
        step();
        check("idle_after_reset", idle_v);

        // Nominal run with all sensors confirming
        I  = 4'b1111;
        St = 1'b1;
        step();
        check("nom_start_edge", pk(4'b0001, 1'b0, 1'b1, 1'b0, 2'd0));
        St = 1'b0;
        exp_q.push_back(pk(4'b0001, 1'b0, 1'b1, 1'b0, 2'd0));
        exp_q.push_back(pk(4'b0011, 1'b0, 1'b1, 1'b0, 2'd0));
        exp_q.push_back(pk(4'b0011, 1'b0, 1'b1, 1'b0, 2'd0));
        exp_q.push_back(pk(4'b0111, 1'b0, 1'b1, 1'b0, 2'd0));
        exp_q.push_back(pk(4'b0111, 1'b0, 1'b1, 1'b0, 2'd0));
        exp_q.push_back(pk(4'b1111, 1'b0, 1'b1, 1'b0, 2'd0));
        exp_q.push_back(pk(4'b1111, 1'b0, 1'b1, 1'b0, 2'd0));
        exp_q.push_back(pk(4'b1111, 1'b1, 1'b0, 1'b0, 2'd0));
        for (int e = 1; e <= 8; e++) begin
            step();
            exp_v = exp_q.pop_front();
            check($sformatf("nom_edge%0d", e), exp_v);
        end

        // Start requests in DONE are ignored
        St = 1'b1;
        step();
        check("done_st_high", pk(4'b1111, 1'b1, 1'b0, 1'b0, 2'd0));
        St = 1'b0;
        step();
        check("done_st_low", pk(4'b1111, 1'b1, 1'b0, 1'b0, 2'd0));

        // Sensor loss in DONE: lowest dropped channel is 1
        I = 4'b0101;
        step();
        check("done_loss", pk(4'b0000, 1'b0, 1'b0, 1'b1, 2'd1));
        step();
        check("fault_hold", pk(4'b0000, 1'b0, 1'b0, 1'b1, 2'd1));

        // Timeout with St held high across the whole stage
        I  = 4'b0000;
        St = 1'b1;
        step();
        check("tmo_start", pk(4'b0001, 1'b0, 1'b1, 1'b0, 2'd0));
        repeat (14) step();
        check("tmo_edge14", pk(4'b0001, 1'b0, 1'b1, 1'b0, 2'd0));
        step();
        check("tmo_edge15", pk(4'b0000, 1'b0, 1'b0, 1'b1, 2'd0));
        step();
        check("held_st_single_start", pk(4'b0000, 1'b0, 1'b0, 1'b1, 2'd0));

        // Restart from FAULT, then glitch on I[0]
        St = 1'b0;
        step();
        St = 1'b1;
        step();
        check("restart", pk(4'b0001, 1'b0, 1'b1, 1'b0, 2'd0));
        St = 1'b0;
        I  = 4'b0001;
        step();
        I = 4'b0000;
        repeat (3) step();
        check("glitch_low", pk(4'b0001, 1'b0, 1'b1, 1'b0, 2'd0));
        I = 4'b0001;
        step();
        check("glitch_high1", pk(4'b0001, 1'b0, 1'b1, 1'b0, 2'd0));
        step();
        check("glitch_high2", pk(4'b0011, 1'b0, 1'b1, 1'b0, 2'd0));

        // Confirm lands exactly on the timeout edge of stage 1
        repeat (13) step();
        check("coin_edge13", pk(4'b0011, 1'b0, 1'b1, 1'b0, 2'd0));
        I = 4'b0011;
        step();
        check("coin_edge14", pk(4'b0011, 1'b0, 1'b1, 1'b0, 2'd0));
        step();
        check("coin_edge15", pk(4'b0111, 1'b0, 1'b1, 1'b0, 2'd0));

        // Sensor loss in stage 2 on channel 0
        I = 4'b0110;
        step();
        check("run_loss", pk(4'b0000, 1'b0, 1'b0, 1'b1, 2'd0));

        // Asynchronous reset between edges while O=0011
        I  = 4'b1111;
        St = 1'b1;
        step();
        St = 1'b0;
        step();
        step();
        check("pre_async", pk(4'b0011, 1'b0, 1'b1, 1'b0, 2'd0));
        #2;
        Clr = 1'b0;
        #1;
        check("async_reset", idle_v);
        #2;
        Clr = 1'b1;
        step();
        step();
        check("no_resume", idle_v);
        St = 1'b1;
        step();
        check("start_after_reset", pk(4'b0001, 1'b0, 1'b1, 1'b0, 2'd0));

        // St already high when reset is released
        #1;
        Clr = 1'b0;
        #1;
        check("reset_st_high", idle_v);
        #2;
        Clr = 1'b1;
        step();
        check("start_on_release", pk(4'b0001, 1'b0, 1'b1, 1'b0, 2'd0));
        St = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/init_seq_ctrl.md
INIT_SEQ_CTRL -- requirements
Module: init_seq_ctrl

Interface
REQ-001 Parameter N_CH, default 4, is the number of sequenced channels, legal range 2..16.
REQ-002 Parameter DEB_CYC, default 2, is the number of consecutive high samples needed to confirm a channel, legal range 1..15.
REQ-003 Parameter TMO_CYC, default 15, is the number of cycles allowed per stage before a timeout fault, legal range 2..65535, and TMO_CYC SHALL exceed DEB_CYC.
REQ-004 Ck  input  1  single system clock; all state changes occur on its rising edge.
REQ-005 Clr  input  1  reset, asynchronous and active-low.
REQ-006 St  input  1  start request; only its rising edge is significant.
REQ-007 I  input  N_CH  per-channel confirmation sensors; I[k] high means channel k is confirmed.
REQ-008 O  output  N_CH  per-channel actuator enables.
REQ-009 H1  output  1  sequence complete; all channels are on and confirmed.
REQ-010 Busy  output  1  sequence in progress.
REQ-011 Flt  output  1  fault latched.
REQ-012 FltIdx  output  max(1,$clog2(N_CH))  index of the faulting channel.

Function
REQ-013 The block SHALL be an FSM with four states: IDLE, RUN, DONE and FAULT. It SHALL hold a stage index s, a debounce counter and a stage timer. All outputs SHALL be registered.
REQ-014 The start event SHALL be defined as St & ~St_q, where St_q is St registered on Ck. Holding St high SHALL produce only one start.
REQ-015 In IDLE, a start event SHALL move the FSM to RUN with s=0 and both counters at 0.
REQ-016 In RUN, O SHALL be high for bits 0..s and low for all other bits, i.e. enables accumulate. Busy SHALL be 1.
REQ-017 Debounce: each edge with I[s]=1 SHALL increment the debounce counter, and an edge with I[s]=0 SHALL clear it. The channel is confirmed on the DEB_CYC-th consecutive high sample.
REQ-018 On confirm with s<N_CH-1, the block SHALL set s=s+1 and clear both counters. On confirm with s=N_CH-1, it SHALL go to DONE.
REQ-019 The stage timer SHALL count cycles spent in the current stage. If the TMO_CYC-th edge after stage entry arrives without a confirm, the block SHALL go to FAULT with FltIdx=s.
REQ-020 Sensor loss: in RUN, if any I[j]=0 for j<s, the block SHALL go to FAULT with FltIdx set to the lowest such j.
REQ-021 When events coincide on one edge, priority SHALL be: sensor loss, then confirm, then timeout. A confirm on the timeout edge SHALL advance the stage rather than fault.
REQ-022 In DONE, the outputs SHALL be O all ones, H1=1 and Busy=0. Start events SHALL be ignored. Any I[j]=0 SHALL cause FAULT with FltIdx set to the lowest such j.
REQ-023 In FAULT, the outputs SHALL be O=0, Flt=1, Busy=0 and H1=0, with FltIdx held. A start event SHALL clear Flt and FltIdx and enter RUN with s=0.
REQ-024 In IDLE, the outputs SHALL be O=0, H1=0, Busy=0 and Flt=0.
REQ-025 The outputs SHALL reflect a state transition on the same edge that causes it, giving a latency of one edge from the sampled input.

Reset
REQ-026 Clr=0 SHALL immediately, without waiting for Ck, force IDLE with s=0, counters=0, St_q=0, O=0, H1=0, Busy=0, Flt=0 and FltIdx=0.
REQ-027 Reset released mid-sequence SHALL NOT resume the sequence; a new start event is required.
REQ-028 If St is already high when Clr is released, St_q=0 SHALL cause a start on the first edge after release.

Verification (defaults N_CH=4, DEB_CYC=2, TMO_CYC=15)
REQ-029 Nominal run: pulse St, then hold each I[s] high from stage entry. The bench SHALL see O step 0001, 0011, 0111, 1111 at 2-edge intervals. H1=1 and Busy=0 SHALL occur 8 edges after the start edge.
REQ-030 Glitch rejection: I[0] is high for 1 cycle, then low for 3 cycles, then high. The bench SHALL see O stay 0001 through the glitch, then step to 0011 on the 2nd high edge.
REQ-031 Timeout: start with I=0. The bench SHALL see Flt=1, FltIdx=0 and O=0 on the 15th edge after the start. A new St rising edge SHALL restart the sequence at O=0001 with Flt=0.
REQ-032 Sensor loss: in stage 2 (O=0111), drop I[0]. The bench SHALL see FAULT with FltIdx=0 on the next edge. Separately, in DONE drop I[3] and I[1]; the bench SHALL see FltIdx=1.
REQ-033 Coincidence and start handling: a confirm on the 15th edge of a stage SHALL advance the stage, not fault. St held high for 4 cycles SHALL give a single start. St in DONE SHALL leave the outputs unchanged.
REQ-034 Asynchronous reset: assert Clr=0 between edges while O=0011. The bench SHALL see O=0 and Busy=0 before the next Ck edge. After release, the outputs SHALL stay in IDLE until St rises.
